nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl_if.sv | 49 ++++
 rtl/nibble_serial_add_ctrl.sv | 107 ++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// Bundle for the two-requester nibble-serial add controller: request, adder-slice and result channels.
// The controller connects through the slave view; requesters, adder slice and result sink use master.
interface nibble_serial_add_ctrl_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         req0_valid;
   logic         req1_valid;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         req0_cin;
   logic         req1_cin;
   logic         req0_ready;
   logic         req1_ready;

   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_cin;
   logic [3:0]   add_s;
   logic         add_cout;

   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_sum;
   logic         rsp_cout;
   logic         busy;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cin, req1_cin,
      output req0_ready, req1_ready,
      output add_a, add_b, add_cin,
      input  add_s, add_cout,
      output rsp_valid, rsp_id, rsp_sum, rsp_cout, busy,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cin, req1_cin,
      input  req0_ready, req1_ready,
      input  add_a, add_b, add_cin,
      output add_s, add_cout,
      input  rsp_valid, rsp_id, rsp_sum, rsp_cout, busy,
      output rsp_ready
   );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Round-robin arbiter feeding a W-bit add through an external 4-bit slice, one nibble per cycle,
// LSB nibble first, with a held result until the sink accepts it.
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   nibble_serial_add_ctrl_if.slave   bus
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

   state_e           state_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx_q;
   logic [W-1:0]     sum_q;
   logic             cout_q;
   logic             id_q;
   logic             last_q;

   logic             grant;
   logic             accept;
   logic             ready0;
   logic             ready1;
   logic [IDX_W+1:0] base;
   logic             in_add;

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         grant = ~last_q;
      end else if (bus.req1_valid) begin
         grant = 1'b1;
      end
   end

   // rst_n gates the strobes so nothing is offered while reset is held, even with valid high.
   assign ready0 = rst_n && (state_q == IDLE) && bus.req0_valid && !grant;
   assign ready1 = rst_n && (state_q == IDLE) && bus.req1_valid &&  grant;
   assign accept = ready0 || ready1;

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;

   assign in_add      = (state_q == ADD);
   assign base        = {idx_q, 2'b00};
   assign bus.add_a   = in_add ? a_q[base +: 4] : 4'h0;
   assign bus.add_b   = in_add ? b_q[base +: 4] : 4'h0;
   assign bus.add_cin = in_add ? carry_q : 1'b0;

   assign bus.rsp_valid = (state_q == DONE);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_sum   = sum_q;
   assign bus.rsp_cout  = cout_q;
   assign bus.busy      = (state_q != IDLE);

   // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
   // NOTE: operand registers are reset too; they are few flops and keep X out of add_a/add_b.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= grant ? bus.req1_a   : bus.req0_a;
                  b_q     <= grant ? bus.req1_b   : bus.req0_b;
                  carry_q <= grant ? bus.req1_cin : bus.req0_cin;
                  id_q    <= grant;
                  last_q  <= grant;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  state_q <= ADD;
               end
            end
            ADD: begin
               sum_q[base +: 4] <= bus.add_s;
               carry_q          <= bus.add_cout;
               idx_q            <= idx_q + 1'b1;
               if (idx_q == IDX_W'(NIBBLES - 1)) begin
                  cout_q  <= bus.add_cout;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed scenarios plus random traffic, scored against a
// plain-arithmetic model of arbitration, nibble sequencing and a+b+cin.
module tb_nibble_serial_add_ctrl;
   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         id;
   } txn_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   cyc;

   nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus();

   nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // External 4-bit ripple slice.
   assign {bus.add_cout, bus.add_s} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] nib(input logic [W-1:0] v, input int k);
      return 4'(v >> (4 * k));
   endfunction

   // Carry entering nibble k: carry out of the sum of the k low nibbles plus cin.
   function automatic logic carry_into(input txn_t t, input int k);
      longint unsigned m;
      longint unsigned s;
      m = (64'd1 << (4 * k)) - 1;
      s = (longint'(t.a) & m) + (longint'(t.b) & m) + longint'(t.cin);
      return 1'((s >> (4 * k)) & 1);
   endfunction

   // ---------------- scoreboard / monitor ----------------
   txn_t         exp_q[$];
   bit           grant_log[$];
   logic         tb_last;
   int           accept_cyc;
   int           nib_k;
   logic         prev_valid;
   logic [W-1:0] held_sum;
   logic         held_cout;
   logic         held_id;
   int           hold_cycles;
   int           rsp_count;
   logic [W-1:0] last_sum;
   logic         last_cout;
   logic         last_id;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         tb_last    = 1'b1;
         prev_valid = 1'b0;
         nib_k      = 0;
      end else if (!bus.busy) begin
         logic g;
         logic v0;
         logic v1;
         txn_t t;
         v0 = bus.req0_valid;
         v1 = bus.req1_valid;
         g  = (v0 && v1) ? !tb_last : v1;
         check("idle_ready0", bus.req0_ready, v0 && !g);
         check("idle_ready1", bus.req1_ready, v1 && g);
         check("idle_rsp_valid", bus.rsp_valid, 1'b0);
         check("idle_add_zero", {bus.add_a, bus.add_b, bus.add_cin}, 9'h0);
         if (v0 || v1) begin
            t.id  = g;
            t.a   = g ? bus.req1_a   : bus.req0_a;
            t.b   = g ? bus.req1_b   : bus.req0_b;
            t.cin = g ? bus.req1_cin : bus.req0_cin;
            exp_q.push_back(t);
            grant_log.push_back(g);
            tb_last    = g;
            accept_cyc = cyc + 1;
            nib_k      = 0;
         end
         prev_valid = 1'b0;
      end else if (!bus.rsp_valid) begin
         check("add_readys", {bus.req0_ready, bus.req1_ready}, 2'b00);
         if (exp_q.size() == 0) begin
            check("add_without_accept", 1'b1, 1'b0);
         end else begin
            check("add_a", bus.add_a, nib(exp_q[$].a, nib_k));
            check("add_b", bus.add_b, nib(exp_q[$].b, nib_k));
            check("add_cin", bus.add_cin, carry_into(exp_q[$], nib_k));
         end
         nib_k++;
         prev_valid = 1'b0;
      end else begin
         check("done_readys", {bus.req0_ready, bus.req1_ready}, 2'b00);
         check("done_add_zero", {bus.add_a, bus.add_b, bus.add_cin}, 9'h0);
         if (!prev_valid) begin
            check("rsp_latency", 64'(cyc - accept_cyc), 64'(NIBBLES));
            check("add_cycles", 64'(nib_k), 64'(NIBBLES));
            held_sum    = bus.rsp_sum;
            held_cout   = bus.rsp_cout;
            held_id     = bus.rsp_id;
            hold_cycles = 0;
         end else begin
            check("hold_sum", bus.rsp_sum, held_sum);
            check("hold_cout", bus.rsp_cout, held_cout);
            check("hold_id", bus.rsp_id, held_id);
         end
         if (!bus.rsp_ready) hold_cycles++;
         if (bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 1'b1, 1'b0);
            end else begin
               txn_t t;
               logic [W:0] full;
               t    = exp_q.pop_front();
               full = (W+1)'(t.a) + (W+1)'(t.b) + (W+1)'(t.cin);
               check("rsp_sum", bus.rsp_sum, full[W-1:0]);
               check("rsp_cout", bus.rsp_cout, full[W]);
               check("rsp_id", bus.rsp_id, t.id);
            end
            rsp_count++;
            last_sum  = bus.rsp_sum;
            last_cout = bus.rsp_cout;
            last_id   = bus.rsp_id;
         end
         prev_valid = 1'b1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic check_all_zero(input string tag);
      check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
      check({tag, "_busy"}, bus.busy, 1'b0);
      check({tag, "_rsp_sum"}, bus.rsp_sum, '0);
      check({tag, "_rsp_cout_id"}, {bus.rsp_cout, bus.rsp_id}, 2'b00);
      check({tag, "_readys"}, {bus.req0_ready, bus.req1_ready}, 2'b00);
      check({tag, "_add"}, {bus.add_a, bus.add_b, bus.add_cin}, 9'h0);
   endtask

   task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      if (id) begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_valid = 1'b1;
      end else begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_valid = 1'b1;
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (id ? bus.req1_ready : bus.req0_ready) begin
            got = 1'b1;
            break;
         end
      end
      check("issue_accept_timeout", got, 1'b1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!bus.busy && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check("wait_idle_timeout", done, 1'b1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit seen;
      checks = 0; errors = 0; cyc = 0; rsp_count = 0;
      rst_n = 1'b0;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_cin = 1'b0;
      bus.req1_a = 16'hABCD; bus.req1_b = 16'h1357; bus.req1_cin = 1'b1;
      bus.rsp_ready = 1'b1;
      #1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1 check_all_zero("reset");
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      // Both requesters held valid: grants must alternate starting with 0.
      for (int i = 0; i < 100 && grant_log.size() < 4; i++) begin
         @(posedge clk); #1;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_idle();
      check("rr_count", 64'(grant_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
         check($sformatf("rr_grant%0d", i), grant_log[i], i[0]);
      end

      issue(1'b0, 16'h1234, 16'h0FFF, 1'b0);
      wait_idle();
      check("dir1_sum", last_sum, 16'h2233);
      check("dir1_cout_id", {last_cout, last_id}, 2'b00);

      issue(1'b1, 16'hFFFF, 16'h0000, 1'b1);
      wait_idle();
      check("dir2_sum", last_sum, 16'h0000);
      check("dir2_cout_id", {last_cout, last_id}, 2'b11);

      // Result held with the sink stalled for six DONE cycles.
      bus.rsp_ready = 1'b0;
      issue(1'b0, 16'h7A5C, 16'h91E3, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("stall_rsp_timeout", seen, 1'b1);
      repeat (5) @(negedge clk);
      check("stall_busy", bus.busy, 1'b1);
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_hold_cycles", 64'(hold_cycles), 64'd6);
      check("stall_back_idle", {bus.busy, bus.rsp_valid}, 2'b00);

      // Reset in the second ADD cycle aborts; next request behaves as after power-up.
      issue(1'b0, 16'h4321, 16'h5678, 1'b0);
      begin
         int rc;
         rc = rsp_count;
         @(posedge clk); #2;
         rst_n = 1'b0;
         #1 check_all_zero("abort");
         @(posedge clk); #3;
         rst_n = 1'b1;
         check("abort_no_rsp", 64'(rsp_count), 64'(rc));
      end
      issue(1'b1, 16'h8000, 16'h8000, 1'b0);
      wait_idle();
      check("post_abort_sum", last_sum, 16'h0000);
      check("post_abort_cout_id", {last_cout, last_id}, 2'b11);

      // Random traffic: valids toggle, operands change every cycle, sink stalls randomly.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         bus.req0_valid = ($urandom_range(0, 3) != 0);
         bus.req1_valid = ($urandom_range(0, 3) != 0);
         bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom); bus.req0_cin = 1'($urandom);
         bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom); bus.req1_cin = 1'($urandom);
         bus.rsp_ready = ($urandom_range(0, 2) != 0);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
      wait_idle();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
